elevator_car_model: RTL

ELEVATOR_CAR_MODEL -- requirements
Module: elevator_car_model

---
 rtl/elevator_pkg.sv | 15 +
 rtl/elevator_call_latch.sv | 40 ++++
 rtl/elevator_car_model.sv | 113 +++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator car model.
package elevator_pkg;
   localparam int FLOOR_W           = 4;
   localparam int CALL_W            = 4;
   localparam int DEF_NUM_FLOORS    = 4;
   localparam int DEF_TRAVEL_CYCLES = 100;

   typedef enum logic [2:0] {
      FC_NONE,
      FC_BOTH_MOTORS,
      FC_DOOR_MOTOR,
      FC_DOOR_MISALIGNED,
      FC_LIMIT
   } fault_cause_e;
endpackage

// File: rtl/elevator_call_latch.sv
// Pending-call register: buttons set bits, a door opening at an aligned floor clears them.
module elevator_call_latch
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [CALL_W-1:0]  call_btn,
   input  logic               clr_en,
   input  logic [FLOOR_W-1:0] clr_floor,
   input  logic               hold,
   output logic [CALL_W-1:0]  floor_req
);

   logic [CALL_W-1:0] req_next;

   // Clear wins over a simultaneous press; floors beyond NUM_FLOORS never latch.
   always_comb begin
      req_next = floor_req;
      for (int i = 0; i < CALL_W; i++) begin
         if (i >= NUM_FLOORS) begin
            req_next[i] = 1'b0;
         end else if (clr_en && (clr_floor == FLOOR_W'(i))) begin
            req_next[i] = 1'b0;
         end else if (call_btn[i]) begin
            req_next[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         floor_req <= '0;
      end else if (!hold) begin
         floor_req <= req_next;
      end
   end

endmodule

// File: rtl/elevator_car_model.sv
// Behavioural car position model with call latching.
// Define ELEVATOR_FAULT_DETECT_EN to build in the sticky safety checker.
module elevator_car_model
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
   parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [CALL_W-1:0]  call_btn,
   input  logic               motor_up,
   input  logic               motor_down,
   input  logic               door_open,
   output logic [CALL_W-1:0]  floor_req,
   output logic [FLOOR_W-1:0] current_floor,
   output logic               at_floor,
   output logic               moving,
   output logic               fault
);

   localparam int                 POS_W     = $clog2(TRAVEL_CYCLES);
   localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(TRAVEL_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

   logic [POS_W-1:0] pos_cnt;
   logic             cmd_up;
   logic             cmd_down;
   logic             up_limit;
   logic             down_limit;
   logic             move_up;
   logic             move_down;
   logic             freeze;
   logic             clr_en;

   assign at_floor   = (pos_cnt == '0);
   assign cmd_up     = motor_up & ~motor_down;
   assign cmd_down   = motor_down & ~motor_up;
   assign up_limit   = cmd_up & at_floor & (current_floor == TOP_FLOOR);
   assign down_limit = cmd_down & at_floor & (current_floor == '0);
   assign move_up    = cmd_up & ~up_limit & ~freeze;
   assign move_down  = cmd_down & ~down_limit & ~freeze;
   assign clr_en     = door_open & at_floor & ~motor_up & ~motor_down;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pos_cnt       <= '0;
         current_floor <= '0;
         moving        <= 1'b0;
      end else begin
         moving <= move_up | move_down;
         if (move_up) begin
            if (pos_cnt == POS_LAST) begin
               pos_cnt       <= '0;
               current_floor <= current_floor + FLOOR_W'(1);
            end else begin
               pos_cnt <= pos_cnt + POS_W'(1);
            end
         end else if (move_down) begin
            // Leaving an aligned floor downward lands at the top of the floor below.
            if (at_floor) begin
               pos_cnt       <= POS_LAST;
               current_floor <= current_floor - FLOOR_W'(1);
            end else begin
               pos_cnt <= pos_cnt - POS_W'(1);
            end
         end
      end
   end

`ifdef ELEVATOR_FAULT_DETECT_EN
   fault_cause_e cause;

   always_comb begin
      cause = FC_NONE;
      if (motor_up && motor_down) begin
         cause = FC_BOTH_MOTORS;
      end else if (door_open && (motor_up || motor_down)) begin
         cause = FC_DOOR_MOTOR;
      end else if (door_open && !at_floor) begin
         cause = FC_DOOR_MISALIGNED;
      end else if (up_limit || down_limit) begin
         cause = FC_LIMIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fault <= 1'b0;
      end else if (cause != FC_NONE) begin
         fault <= 1'b1;
      end
   end

   assign freeze = fault;
`else
   assign fault  = 1'b0;
   assign freeze = 1'b0;
`endif

   elevator_call_latch #(
      .NUM_FLOORS(NUM_FLOORS)
   ) u_call_latch (
      .clk       (clk),
      .reset_n   (reset_n),
      .call_btn  (call_btn),
      .clr_en    (clr_en),
      .clr_floor (current_floor),
      .hold      (freeze),
      .floor_req (floor_req)
   );

endmodule
